// File: rtl/lb_mon_pkg.sv
// Shared definitions for the two-copy load-buffer divergence monitor:
// run-state encoding, default widths and the saturating increment helper.
package lb_mon_pkg;

  localparam int DEF_WARMUP_CYCLES = 2;
  localparam int DEF_WINDOW_CYCLES = 12;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_ADDR_W        = 32;
  localparam int DEF_DATA_W        = 32;

  // Widest counter the saturating helper can handle.
  localparam int SAT_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } lb_state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int                   width);
    logic [SAT_MAX_W-1:0] max_v;
    if (width >= SAT_MAX_W) begin
      max_v = '1;
    end else begin
      max_v = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    end
    return (val >= max_v) ? max_v : (val + SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/lb_diverge_cmp.sv
// Combinational per-cycle event detector for one pair of load-buffer entries.
// An event is a valid mismatch, or both valid with differing addresses.
// Optional macro LB_MON_DATA_CMP_EN: also flag both valid with differing data.
module lb_diverge_cmp #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              valid1_i,
  input  logic              valid2_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              event_o
);

  logic both_valid;
  logic valid_mismatch;
  logic addr_mismatch;

  assign both_valid     = valid1_i & valid2_i;
  assign valid_mismatch = valid1_i ^ valid2_i;
  assign addr_mismatch  = both_valid & (addr1_i != addr2_i);

`ifdef LB_MON_DATA_CMP_EN
  logic data_mismatch;
  assign data_mismatch = both_valid & (data1_i != data2_i);
  assign event_o       = valid_mismatch | addr_mismatch | data_mismatch;
`else
  // Data buses are intentionally ignored in this build.
  logic unused_data;
  assign unused_data = ^{data1_i, data2_i};
  assign event_o     = valid_mismatch | addr_mismatch;
`endif

endmodule

// File: rtl/lb_diverge_monitor.sv
// Two-copy load-buffer divergence monitor. After an accepted start it skips
// WARMUP_CYCLES, then compares WINDOW_CYCLES cycles of the two load-buffer
// streams and keeps registered, sticky results (first event cycle/addresses,
// saturating event count) until the next accepted start or reset.
// Optional macro LB_MON_DATA_CMP_EN (in lb_diverge_cmp) adds data compare.
module lb_diverge_monitor
  import lb_mon_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lb_valid1,
  input  logic              lb_valid2,
  input  logic [ADDR_W-1:0] lb_addr1,
  input  logic [ADDR_W-1:0] lb_addr2,
  input  logic [DATA_W-1:0] lb_data1,
  input  logic [DATA_W-1:0] lb_data2,
  output logic              busy,
  output logic              done,
  output logic              diverge_now,
  output logic              diverge_sticky,
  output logic [CNT_W-1:0]  diverge_count,
  output logic [CNT_W-1:0]  first_cycle,
  output logic [ADDR_W-1:0] first_addr1,
  output logic [ADDR_W-1:0] first_addr2
);

  // Phase counter only has to reach the longer of the two phases minus one.
  localparam int PH_MAX = (WARMUP_CYCLES > WINDOW_CYCLES) ? WARMUP_CYCLES : WINDOW_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  lb_state_e         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              now_q, now_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  first_cycle_q, first_cycle_d;
  logic [ADDR_W-1:0] first_addr1_q, first_addr1_d;
  logic [ADDR_W-1:0] first_addr2_q, first_addr2_d;

  logic start_ok;
  logic cmp_event;
  logic hit;

  lb_diverge_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .valid1_i (lb_valid1),
    .valid2_i (lb_valid2),
    .addr1_i  (lb_addr1),
    .addr2_i  (lb_addr2),
    .data1_i  (lb_data1),
    .data2_i  (lb_data2),
    .event_o  (cmp_event)
  );

  // Only a compare-window cycle can produce an event.
  assign hit = (state_q == ST_COMPARE) && cmp_event;

  // Run sequencing: next state, phase counter and start acceptance.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    phase_d  = phase_q;
    start_ok = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          phase_d  = '0;
          state_d  = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_COMPARE;
        end
      end
      ST_WARMUP: begin
        if (phase_q == PH_W'(WARMUP_CYCLES - 1)) begin
          state_d = ST_COMPARE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_COMPARE: begin
        if (phase_q == PH_W'(WINDOW_CYCLES - 1)) begin
          state_d = ST_DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Result bookkeeping: clear on accepted start, count and capture on events.
  always_comb begin
    now_d         = hit;
    sticky_d      = sticky_q;
    count_d       = count_q;
    first_cycle_d = first_cycle_q;
    first_addr1_d = first_addr1_q;
    first_addr2_d = first_addr2_q;
    if (start_ok) begin
      sticky_d      = 1'b0;
      count_d       = '0;
      first_cycle_d = '0;
      first_addr1_d = '0;
      first_addr2_d = '0;
    end else if (hit) begin
      count_d = CNT_W'(sat_inc(SAT_MAX_W'(count_q), CNT_W));
      if (!sticky_q) begin
        sticky_d      = 1'b1;
        first_cycle_d = CNT_W'(phase_q);
        first_addr1_d = lb_addr1;
        first_addr2_d = lb_addr2;
      end
    end
  end

  // State and result registers with asynchronous reset to the idle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      now_q         <= 1'b0;
      sticky_q      <= 1'b0;
      count_q       <= '0;
      first_cycle_q <= '0;
      first_addr1_q <= '0;
      first_addr2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      phase_q       <= phase_d;
      now_q         <= now_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
      first_cycle_q <= first_cycle_d;
      first_addr1_q <= first_addr1_d;
      first_addr2_q <= first_addr2_d;
    end
  end

  assign busy           = (state_q == ST_WARMUP) || (state_q == ST_COMPARE);
  assign done           = (state_q == ST_DONE);
  assign diverge_now    = now_q;
  assign diverge_sticky = sticky_q;
  assign diverge_count  = count_q;
  assign first_cycle    = first_cycle_q;
  assign first_addr1    = first_addr1_q;
  assign first_addr2    = first_addr2_q;

endmodule

// File: tb/tb_lb_diverge_monitor.sv
// Self-checking bench for lb_diverge_monitor: directed table of runs, random
// runs against a window-level reference model, and reset corner cases.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_lb_diverge_monitor;

  localparam int W = 2;
  localparam int N = 12;

  logic        clk;
  logic        reset;
  logic        start;
  logic        lb_valid1, lb_valid2;
  logic [31:0] lb_addr1, lb_addr2, lb_data1, lb_data2;

  logic        busy, done, diverge_now, diverge_sticky;
  logic [7:0]  diverge_count, first_cycle;
  logic [31:0] first_addr1, first_addr2;

  logic        busy_s, done_s, now_s, sticky_s;
  logic [1:0]  count_s, first_cycle_s;
  logic [31:0] first_addr1_s, first_addr2_s;

  lb_diverge_monitor #(
    .WARMUP_CYCLES (W), .WINDOW_CYCLES (N), .CNT_W (8), .ADDR_W (32), .DATA_W (32)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .lb_valid1 (lb_valid1), .lb_valid2 (lb_valid2),
    .lb_addr1 (lb_addr1), .lb_addr2 (lb_addr2),
    .lb_data1 (lb_data1), .lb_data2 (lb_data2),
    .busy (busy), .done (done), .diverge_now (diverge_now),
    .diverge_sticky (diverge_sticky), .diverge_count (diverge_count),
    .first_cycle (first_cycle), .first_addr1 (first_addr1), .first_addr2 (first_addr2)
  );

  lb_diverge_monitor #(
    .WARMUP_CYCLES (W), .WINDOW_CYCLES (N), .CNT_W (2), .ADDR_W (32), .DATA_W (32)
  ) dut_s (
    .clk (clk), .reset (reset), .start (start),
    .lb_valid1 (lb_valid1), .lb_valid2 (lb_valid2),
    .lb_addr1 (lb_addr1), .lb_addr2 (lb_addr2),
    .lb_data1 (lb_data1), .lb_data2 (lb_data2),
    .busy (busy_s), .done (done_s), .diverge_now (now_s),
    .diverge_sticky (sticky_s), .diverge_count (count_s),
    .first_cycle (first_cycle_s), .first_addr1 (first_addr1_s), .first_addr2 (first_addr2_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Per-compare-cycle stimulus for one run.
  logic        sv1 [N];
  logic        sv2 [N];
  logic [31:0] sa1 [N];
  logic [31:0] sa2 [N];
  logic [31:0] sd1 [N];
  logic [31:0] sd2 [N];
  bit          warm_bad;
  bit          start_noise;

  typedef struct {
    string       name;
    int          mode;
    bit          warm_bad;
    int          exp_cnt;
    int          exp_cnt_s;
    int          exp_first;
    bit          exp_sticky;
    logic [31:0] exp_fa1;
    logic [31:0] exp_fa2;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Event rule applied to one compare cycle of the stimulus.
  function automatic bit model_event(input int i);
    bit e;
    e = (sv1[i] != sv2[i]) || (sv1[i] && sv2[i] && (sa1[i] != sa2[i]));
`ifdef LB_MON_DATA_CMP_EN
    e = e || (sv1[i] && sv2[i] && (sd1[i] != sd2[i]));
`endif
    return e;
  endfunction

  task automatic set_base();
    for (int i = 0; i < N; i++) begin
      sv1[i] = 1'b1; sv2[i] = 1'b1;
      sa1[i] = 32'h64; sa2[i] = 32'h64;
      sd1[i] = 32'h5; sd2[i] = 32'h5;
    end
  endtask

  task automatic fill(input int mode);
    set_base();
    case (mode)
      1: sv2[3] = 1'b0;
      2: begin
        sa2[5] = 32'h68;
        sa1[7] = 32'h70; sa2[7] = 32'h74;
      end
      3: begin sd1[4] = 32'h1; sd2[4] = 32'h2; end
      4: for (int i = 0; i < N; i++) sv2[i] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic drive_cycle(input int i);
    lb_valid1 = sv1[i]; lb_valid2 = sv2[i];
    lb_addr1  = sa1[i]; lb_addr2  = sa2[i];
    lb_data1  = sd1[i]; lb_data2  = sd2[i];
  endtask

  // Mismatching traffic that must be ignored outside the compare window.
  task automatic drive_garbage();
    lb_valid1 = 1'b1; lb_valid2 = 1'b0;
    lb_addr1  = 32'h11; lb_addr2 = 32'h22;
    lb_data1  = 32'h1; lb_data2  = 32'h2;
  endtask

  task automatic drive_clean();
    lb_valid1 = 1'b1; lb_valid2 = 1'b1;
    lb_addr1  = 32'h64; lb_addr2 = 32'h64;
    lb_data1  = 32'h5; lb_data2  = 32'h5;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},    32'(busy), 32'd0);
    check({tag, " done"},    32'(done), 32'd0);
    check({tag, " now"},     32'(diverge_now), 32'd0);
    check({tag, " sticky"},  32'(diverge_sticky), 32'd0);
    check({tag, " count"},   32'(diverge_count), 32'd0);
    check({tag, " count_s"}, 32'(count_s), 32'd0);
    check({tag, " fcycle"},  32'(first_cycle), 32'd0);
    check({tag, " faddr1"},  first_addr1, 32'd0);
    check({tag, " faddr2"},  first_addr2, 32'd0);
  endtask

  // One full run from an idle/done monitor; per-cycle checks against the model.
  task automatic do_run(input string tag);
    int          cnt;
    int          first;
    logic [31:0] f1, f2;
    bit          e;
    cnt = 0; first = -1; f1 = 32'd0; f2 = 32'd0;
    @(negedge clk);
    start = 1'b1;
    drive_garbage();
    @(negedge clk);
    start = start_noise;
    check($sformatf("%s accept busy", tag),   32'(busy), 32'd1);
    check($sformatf("%s accept sticky", tag), 32'(diverge_sticky), 32'd0);
    check($sformatf("%s accept count", tag),  32'(diverge_count), 32'd0);
    check($sformatf("%s accept now", tag),    32'(diverge_now), 32'd0);
    for (int w = 0; w < W; w++) begin
      if (warm_bad) drive_garbage(); else drive_clean();
      @(negedge clk);
      check($sformatf("%s warm%0d now", tag, w),   32'(diverge_now), 32'd0);
      check($sformatf("%s warm%0d count", tag, w), 32'(diverge_count), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      drive_cycle(i);
      if (start_noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = model_event(i);
      if (e) begin
        cnt++;
        if (first < 0) begin first = i; f1 = sa1[i]; f2 = sa2[i]; end
      end
      check($sformatf("%s c%0d now", tag, i),     32'(diverge_now), 32'(e));
      check($sformatf("%s c%0d count", tag, i),   32'(diverge_count), 32'(sat(cnt, 255)));
      check($sformatf("%s c%0d count_s", tag, i), 32'(count_s), 32'(sat(cnt, 3)));
      check($sformatf("%s c%0d sticky", tag, i),  32'(diverge_sticky), 32'(first >= 0));
      check($sformatf("%s c%0d busy", tag, i),    32'(busy), 32'(i < N - 1));
      check($sformatf("%s c%0d done", tag, i),    32'(done), 32'(i == N - 1));
    end
    start = 1'b0;
    drive_garbage();
    check($sformatf("%s fcycle", tag), 32'(first_cycle), (first >= 0) ? 32'(first) : 32'd0);
    check($sformatf("%s faddr1", tag), first_addr1, f1);
    check($sformatf("%s faddr2", tag), first_addr2, f2);
    @(negedge clk);
    check($sformatf("%s post now", tag),  32'(diverge_now), 32'd0);
    check($sformatf("%s post done", tag), 32'(done), 32'd1);
    check($sformatf("%s post count", tag), 32'(diverge_count), 32'(sat(cnt, 255)));
  endtask

  initial begin
    tbl[0] = '{"ident",   0, 1'b0, 0,  0, 0, 1'b0, 32'h0,  32'h0};
    tbl[1] = '{"vmis3",   1, 1'b0, 1,  1, 3, 1'b1, 32'h64, 32'h64};
    tbl[2] = '{"amis57",  2, 1'b0, 2,  2, 5, 1'b1, 32'h64, 32'h68};
`ifdef LB_MON_DATA_CMP_EN
    tbl[3] = '{"dmis4",   3, 1'b0, 1,  1, 4, 1'b1, 32'h64, 32'h64};
`else
    tbl[3] = '{"dmis4",   3, 1'b0, 0,  0, 0, 1'b0, 32'h0,  32'h0};
`endif
    tbl[4] = '{"satall",  4, 1'b1, 12, 3, 0, 1'b1, 32'h64, 32'h64};

    reset = 1'b1;
    start = 1'b0;
    start_noise = 1'b0;
    warm_bad = 1'b0;
    drive_garbage();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // Directed table of runs.
    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].mode);
      warm_bad = tbl[t].warm_bad;
      start_noise = 1'b0;
      do_run(tbl[t].name);
      check({tbl[t].name, " tbl count"},   32'(diverge_count), 32'(tbl[t].exp_cnt));
      check({tbl[t].name, " tbl count_s"}, 32'(count_s), 32'(tbl[t].exp_cnt_s));
      check({tbl[t].name, " tbl sticky"},  32'(diverge_sticky), 32'(tbl[t].exp_sticky));
      check({tbl[t].name, " tbl fcycle"},  32'(first_cycle), 32'(tbl[t].exp_first));
      check({tbl[t].name, " tbl faddr1"},  first_addr1, tbl[t].exp_fa1);
      check({tbl[t].name, " tbl faddr2"},  first_addr2, tbl[t].exp_fa2);
    end

    // Randomized runs, start toggled during the run to confirm it is ignored.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        sv1[i] = ($urandom_range(0, 3) != 0);
        sv2[i] = ($urandom_range(0, 3) != 0);
        sa1[i] = 32'h100 + 32'($urandom_range(0, 3)) * 4;
        sa2[i] = ($urandom_range(0, 3) == 0) ? 32'h100 + 32'($urandom_range(0, 3)) * 4 : sa1[i];
        sd1[i] = 32'($urandom_range(0, 7));
        sd2[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : sd1[i];
      end
      warm_bad = 1'($urandom_range(0, 1));
      start_noise = 1'($urandom_range(0, 1));
      do_run($sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start_noise = 1'b0;

    // Reset in the middle of the compare window after one event.
    fill(0);
    @(negedge clk);
    start = 1'b1;
    drive_clean();
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    drive_garbage();
    @(negedge clk);
    check("midrst pre now",    32'(diverge_now), 32'd1);
    check("midrst pre count",  32'(diverge_count), 32'd1);
    check("midrst pre sticky", 32'(diverge_sticky), 32'd1);
    check("midrst pre faddr1", first_addr1, 32'h11);
    drive_clean();
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    // Start held together with reset: reset wins.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("rst+start busy", 32'(busy), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no resume busy", 32'(busy), 32'd0);
    check("no resume done", 32'(done), 32'd0);

    // Fresh run after the reset must be clean.
    fill(0);
    warm_bad = 1'b1;
    do_run("after_rst");
    check("after_rst count",  32'(diverge_count), 32'd0);
    check("after_rst sticky", 32'(diverge_sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
